// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the cache miss/refill path: refill FSM state
// encoding, default tag/index widths and the number of byte beats per
// 32-bit line word.
package cache_pkg;

  localparam int TAG_W_DEF = 20;
  localparam int IDX_W_DEF = 10;
  localparam int BEATS     = 4;
  localparam int BEAT_W    = $clog2(BEATS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_BYTE = 3'd1,
    ST_WR_BYTE = 3'd2,
    ST_FILL    = 3'd3,
    ST_ABORT   = 3'd4
  } refill_state_e;

endpackage

// File: rtl/byte_lane_packer.sv
// byte_lane_packer
// Beat-indexed byte lane access on a 32-bit little-endian word.
//   i_ins_word/i_ins_beat/i_ins_byte -> o_ins_word : word with one byte replaced
//   i_ext_word/i_ext_beat            -> o_ext_byte : one byte extracted
// Purely combinational.
module byte_lane_packer
  import cache_pkg::*;
(
  input  logic [31:0]       i_ins_word,
  input  logic [BEAT_W-1:0] i_ins_beat,
  input  logic [7:0]        i_ins_byte,
  output logic [31:0]       o_ins_word,
  input  logic [31:0]       i_ext_word,
  input  logic [BEAT_W-1:0] i_ext_beat,
  output logic [7:0]        o_ext_byte
);

  always_comb begin
    o_ins_word = i_ins_word;
    o_ins_word[{i_ins_beat, 3'b000} +: 8] = i_ins_byte;
  end

  assign o_ext_byte = i_ext_word[{i_ext_beat, 3'b000} +: 8];

endmodule

// File: rtl/miss_refill_unit.sv
// miss_refill_unit
// Serves one cache miss at a time by moving a 32-bit word over a byte-wide
// memory port in four beats, then writes the line into the cache.
//   clk, rst_n                        : clock, async active-low reset
//   miss_req/req_addr/req_write/req_wdata, req_ready : request handshake
//   mem_addr/mem_rd/mem_wr/mem_wdata, mem_rdata/mem_ack : byte memory port
//   fill_valid/fill_index/fill_tag/fill_data : cache line write (1-cycle)
//   err                               : 1-cycle pulse on beat timeout
//
// state      | meaning
// IDLE       | ready for a request
// RD_BYTE    | reading byte 'beat' from memory
// WR_BYTE    | writing byte 'beat' to memory
// FILL       | pulse fill_valid with the assembled/captured word
// ABORT      | pulse err after a beat timed out
module miss_refill_unit
  import cache_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int IDX_W   = IDX_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             miss_req,
  input  logic [31:0]      req_addr,
  input  logic             req_write,
  input  logic [31:0]      req_wdata,
  output logic             req_ready,
  output logic [31:0]      mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  input  logic [7:0]       mem_rdata,
  input  logic             mem_ack,
  output logic             fill_valid,
  output logic [IDX_W-1:0] fill_index,
  output logic [TAG_W-1:0] fill_tag,
  output logic [31:0]      fill_data,
  output logic             err
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  refill_state_e     r_state;
  logic [31:2]       r_base;
  logic              r_write;
  logic [31:0]       r_wdata;
  logic [31:0]       r_data;
  logic [BEAT_W-1:0] r_beat;
  logic [WAIT_W-1:0] r_wait;

  logic [BEAT_W-1:0] w_beat_nxt;
  logic [31:0]       w_data_ins;
  logic [7:0]        w_wbyte_nxt;

  assign w_beat_nxt = r_beat + 1'b1;
  assign req_ready  = (r_state == ST_IDLE);

  byte_lane_packer u_packer (
    .i_ins_word (r_data),
    .i_ins_beat (r_beat),
    .i_ins_byte (mem_rdata),
    .o_ins_word (w_data_ins),
    .i_ext_word (r_wdata),
    .i_ext_beat (w_beat_nxt),
    .o_ext_byte (w_wbyte_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_base     <= '0;
      r_write    <= 1'b0;
      r_wdata    <= '0;
      r_data     <= '0;
      r_beat     <= '0;
      r_wait     <= '0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      fill_valid <= 1'b0;
      fill_index <= '0;
      fill_tag   <= '0;
      fill_data  <= '0;
      err        <= 1'b0;
    end else begin
      fill_valid <= 1'b0;
      err        <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (miss_req) begin
            r_base    <= req_addr[31:2];
            r_write   <= req_write;
            r_wdata   <= req_wdata;
            r_beat    <= '0;
            r_wait    <= '0;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_rd    <= ~req_write;
            mem_wr    <= req_write;
            mem_wdata <= req_write ? req_wdata[7:0] : 8'h00;
            r_state   <= req_write ? ST_WR_BYTE : ST_RD_BYTE;
          end
        end
        ST_RD_BYTE, ST_WR_BYTE: begin
          if (mem_ack) begin
            r_wait <= '0;
            if (r_state == ST_RD_BYTE) r_data <= w_data_ins;
            if (r_beat == BEAT_W'(BEATS - 1)) begin
              mem_rd    <= 1'b0;
              mem_wr    <= 1'b0;
              mem_wdata <= '0;
              r_beat    <= '0;
              r_state   <= ST_FILL;
            end else begin
              r_beat   <= w_beat_nxt;
              mem_addr <= {r_base, w_beat_nxt};
              if (r_state == ST_WR_BYTE) mem_wdata <= w_wbyte_nxt;
            end
          end else if (r_wait == WAIT_W'(TIMEOUT - 1)) begin
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_wdata <= '0;
            r_wait    <= '0;
            r_beat    <= '0;
            r_state   <= ST_ABORT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        ST_FILL: begin
          fill_valid <= 1'b1;
          fill_tag   <= r_base[31 -: TAG_W];
          fill_index <= r_base[2 +: IDX_W];
          fill_data  <= r_write ? r_wdata : r_data;
          r_state    <= ST_IDLE;
        end
        ST_ABORT: begin
          err     <= 1'b1;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/miss_refill_unit.md
MISS_REFILL_UNIT -- requirements
Module: miss_refill_unit

Interface
REQ-001 SHALL have parameter TAG_W, default 20, tag width (address[31:12]).
REQ-002 SHALL have parameter IDX_W, default 10, line index width (address[11:2]).
REQ-003 SHALL have parameter TIMEOUT, default 255, max wait cycles per memory beat before abort.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge; the block uses one clock.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port miss_req  in  1  request from cache (refill or write-through).
REQ-007 SHALL have port req_addr  in  32  byte address of request.
REQ-008 SHALL have port req_write  in  1  1=write-through with allocate, 0=read refill.
REQ-009 SHALL have port req_wdata  in  32  write data, little-endian bytes.
REQ-010 SHALL have port req_ready  out  1  high only in IDLE.
REQ-011 SHALL have ports mem_addr out 32, mem_rd out 1, mem_wr out 1 and mem_wdata out 8, forming the byte-wide memory request.
REQ-012 SHALL have ports mem_rdata in 8 and mem_ack in 1, where mem_ack is the per-byte completion strobe.
REQ-013 SHALL have ports fill_valid out 1, fill_index out IDX_W, fill_tag out TAG_W and fill_data out 32, forming the cache line write.
REQ-014 SHALL have port err  out  1  one-cycle pulse on timeout abort.

Function
REQ-015 SHALL accept a request on a rising edge where miss_req and req_ready are both high, capturing {req_addr[31:2],2'b00}, req_write and req_wdata.
REQ-016 SHALL ignore miss_req outside IDLE, with no queueing.
REQ-017 SHALL use states IDLE, RD_BYTE, WR_BYTE, FILL and ABORT: IDLE->RD_BYTE (req_write=0) or WR_BYTE (req_write=1) on accept; RD/WR->FILL after beat 3 ack; RD/WR->ABORT on timeout; FILL->IDLE; ABORT->IDLE, each after one cycle.
REQ-018 SHALL drive mem_addr={base[31:2],beat} with the 2-bit beat counter running 0..3, so it never carries into bit 2.
REQ-019 SHALL hold mem_rd (RD_BYTE) or mem_wr (WR_BYTE) high, and mem_addr/mem_wdata stable, until mem_ack.
REQ-020 SHALL, in WR_BYTE, drive mem_wdata=wdata[8*beat+7:8*beat].
REQ-021 SHALL, in RD_BYTE, store mem_rdata into data[8*beat+7:8*beat] on each acked edge.
REQ-022 SHALL advance beat on each acked edge and reset the wait counter.
REQ-023 SHALL ignore mem_ack outside RD_BYTE/WR_BYTE.
REQ-024 SHALL, in FILL, pulse fill_valid for exactly one cycle with fill_tag=base[31:12], fill_index=base[11:2], and fill_data=assembled data (read) or captured wdata (write).
REQ-025 SHALL count idle wait cycles per beat; when the count reaches TIMEOUT with no ack, SHALL enter ABORT, pulse err for one cycle, and produce no fill_valid.
REQ-026 SHALL, with mem_ack high every cycle, give an accept-edge-to-fill_valid latency of 5 cycles (4 beats + FILL); the next accept is possible 6 edges after the previous one.
REQ-027 SHALL register fill_*, err, mem_* outputs, and SHALL decode req_ready combinationally from state.

Reset
REQ-028 SHALL force IDLE, beat=0, wait=0 and data=0 on rst_n low, immediately and asynchronously.
REQ-029 SHALL hold all outputs at 0 during reset, except req_ready=1.
REQ-030 SHALL, on reset mid-operation, drop the in-flight transfer with no fill_valid or err, deasserting mem_rd/mem_wr immediately.

Structure
REQ-031 SHALL take the state enum, TAG_W/IDX_W defaults and the beat count (4) from shared package cache_pkg.
REQ-032 SHALL instantiate one sub-module, byte_lane_packer, which performs beat-indexed byte insert/extract on a 32-bit word.

Verification
REQ-033 SHALL cover: mem bytes 0x4..0x7=09,00,00,00, read req_addr 0x00000004, ack every cycle -> fill_valid at cycle 5, fill_data 0x00000009, tag 0x00000, index 1.
REQ-034 SHALL cover: write req_addr 0x00000008, wdata 0x0000000F -> mem writes 0x8=0F, 0x9..0xB=00 in order, then fill index 2, fill_data 0x0000000F.
REQ-035 SHALL cover: read req_addr 0x0000100E -> mem_addr 0x100C..0x100F, fill_tag 0x00001, index 3.
REQ-036 SHALL cover: read with ack delayed 3 cycles per beat -> fill_valid 17 cycles after accept, with mem_addr stable during each wait.
REQ-037 SHALL cover: TIMEOUT=4, no ack -> err pulse 5 cycles after accept, no fill_valid, req_ready high next cycle.
REQ-038 SHALL cover: rst_n low during beat 2, and a miss_req asserted while busy -> no fill, IDLE after reset, busy-time request never served.
